// File: rtl/spi_slave_rx_if.sv
// Signal bundle between the SPI pin front end and the register/command decoder side.
// The slave modport is the front end itself; master is whoever drives the pins and reply data.
interface spi_slave_rx_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 sck;
    logic                 mosi;
    logic                 cs;
    logic                 miso;
    logic                 miso_oe;
    logic [WIDTH-1:0]     rx_data;
    logic                 rx_valid;
    logic [WIDTH-1:0]     tx_data;
    logic                 tx_load;
    logic [WIDTH-1:0]     frame_data;
    logic [CNT_WIDTH-1:0] frame_words;
    logic                 frame_err;
    logic                 frame_valid;
    logic                 busy;

    modport slave (
        input  sck, mosi, cs, tx_data,
        output miso, miso_oe, rx_data, rx_valid, tx_load,
        output frame_data, frame_words, frame_err, frame_valid, busy
    );

    modport master (
        output sck, mosi, cs, tx_data,
        input  miso, miso_oe, rx_data, rx_valid, tx_load,
        input  frame_data, frame_words, frame_err, frame_valid, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI slave front end: oversamples raw SCK/MOSI/CS in the clk domain, assembles words,
// reports per-word strobes and a per-frame summary, and shifts reply words out on MISO.
module spi_slave_rx #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 1,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input logic           clk,
    input logic           rst,
    spi_slave_rx_if.slave bus
);

    localparam int unsigned BitW       = $clog2(WIDTH);
    localparam bit          SampleRise = (CPOL == CPHA);
    localparam bit          MsbFirst   = (MSB_FIRST != 0);

    typedef enum logic [1:0] {StUnarmed, StIdle, StFrame} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sck_d_q, cs_d_q;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0]   word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]       last_word_q, last_word_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0]       frame_data_q, frame_data_d;
    logic [CNT_WIDTH-1:0]   frame_words_q, frame_words_d;
    logic                   frame_err_q, frame_err_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   tx_load;

    logic sck_s, mosi_s, cs_s;
    logic edge_en, sample_evt, shift_evt;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    // Armed covers both idle and in-frame; a mid-frame reset stays unarmed until CS is seen high.
    assign edge_en    = !cs_d_q && (state_q != StUnarmed);
    assign sample_evt = edge_en && (SampleRise ? (sck_s && !sck_d_q) : (!sck_s && sck_d_q));
    assign shift_evt  = edge_en && (SampleRise ? (!sck_s && sck_d_q) : (sck_s && !sck_d_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sck_d_q     <= 1'b0;
            cs_d_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
            sck_d_q     <= sck_s;
            cs_d_q      <= cs_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StUnarmed;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            last_word_q   <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_data_q  <= '0;
            frame_words_q <= '0;
            frame_err_q   <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            last_word_q   <= last_word_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_data_q  <= frame_data_d;
            frame_words_q <= frame_words_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        last_word_d   = last_word_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_data_d  = frame_data_q;
        frame_words_d = frame_words_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = 1'b0;
        tx_load       = 1'b0;

        unique case (state_q)
            StUnarmed: begin
                if (cs_s) state_d = StIdle;
            end
            StIdle: begin
                if (!cs_s && cs_d_q) begin
                    state_d    = StFrame;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    tx_shift_d = bus.tx_data;
                    tx_load    = 1'b1;
                end
            end
            StFrame: ;
            default: state_d = StUnarmed;
        endcase

        if (sample_evt) begin
            rx_shift_d = MsbFirst ? {rx_shift_q[WIDTH-2:0], mosi_s}
                                  : {mosi_s, rx_shift_q[WIDTH-1:1]};
            if (bit_cnt_q == BitW'(WIDTH - 1)) begin
                bit_cnt_d   = '0;
                rx_data_d   = rx_shift_d;
                rx_valid_d  = 1'b1;
                last_word_d = rx_shift_d;
                if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // At bit 0 of the first word (CPHA=1 leading edge) hold, so the first reply bit survives.
        if (shift_evt) begin
            if (bit_cnt_q == '0) begin
                if (word_cnt_q != '0) begin
                    tx_shift_d = bus.tx_data;
                    tx_load    = 1'b1;
                end
            end else begin
                tx_shift_d = MsbFirst ? {tx_shift_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, tx_shift_q[WIDTH-1:1]};
            end
        end

        // Close after the sample path so a coincident final bit is counted in the summary.
        if (state_q == StFrame && cs_s && !cs_d_q) begin
            state_d       = StIdle;
            frame_words_d = word_cnt_d;
            frame_err_d   = (bit_cnt_d != '0);
            if (word_cnt_d != '0) frame_data_d = last_word_d;
            frame_valid_d = 1'b1;
        end
    end

    assign bus.miso        = MsbFirst ? tx_shift_q[WIDTH-1] : tx_shift_q[0];
    assign bus.miso_oe     = (state_q == StFrame);
    assign bus.busy        = (state_q == StFrame);
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_load     = tx_load;
    assign bus.frame_data  = frame_data_q;
    assign bus.frame_words = frame_words_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_valid = frame_valid_q;

endmodule
